// File: rtl/logicn_filt_brick.sv
// logicn_filt_brick: mode-selectable N-input gate with a registered, glitch-filtered output
module logicn_filt_brick #(
    parameter int   N_IN     = 2,
    parameter int   FILT_CYC = 4,
    parameter logic RST_VAL  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            CELV,
    input  logic            CELG,
    input  logic            SUB,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic [N_IN-1:0] i,
    output logic            o,
    output logic            chg,
    output logic            busy
);
    localparam int            CW   = $clog2(FILT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(FILT_CYC - 1);
    logic [CW-1:0] cnt;
    logic          raw;
    logic          unused_pwr;
    assign unused_pwr = ^{CELV, CELG, SUB};
    // gate function: mode 0 NAND, 1 AND, 2 NOR, 3 OR
    always_comb begin
        raw = mode[1] ? (mode[0] ? |i : ~|i) : (mode[0] ? &i : ~&i);
    end
    // o only follows raw after FILT_CYC consecutive differing samples; en low freezes o and restarts the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o   <= RST_VAL;
            cnt <= '0;
            chg <= 1'b0;
        end else if (!en || raw == o) begin
            cnt <= '0;
            chg <= 1'b0;
        end else if (cnt == LAST) begin
            o   <= raw;
            cnt <= '0;
            chg <= 1'b1;
        end else begin
            cnt <= cnt + CW'(1);
            chg <= 1'b0;
        end
    end
    assign busy = (cnt != '0);
endmodule
